fpu_result_buffer: RTL and testbench

//  Downstream stage of CFpu. Captures each valid FPU result {m_dataOut, m_statusOut} into a small FIFO.

---
 rtl/fpu_result_buffer_if.sv | 29 ++
 rtl/fpu_result_buffer.sv | 68 ++++++
 tb/tb_fpu_result_buffer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpu_result_buffer_if.sv
// fpu_result_buffer_if: FPU status type plus the result/handshake bundle between CFpu, the buffer and its consumer.
package FPU_types;
  typedef enum logic [1:0] {EXACT, OVERFLOW, UNDERFLOW, INEXACT} g_eStatus;
endpackage

interface fpu_result_buffer_if #(parameter int DEPTH = 4, parameter int CNT_W = 8);
  import FPU_types::*;
  logic                   m_inValid;
  logic [31:0]            m_dataIn;
  g_eStatus               m_statusIn;
  logic                   m_inReady;
  logic                   m_outValid;
  logic                   m_outReady;
  logic [31:0]            m_dataOut;
  g_eStatus               m_statusOut;
  logic [$clog2(DEPTH):0] m_level;
  logic [2:0]             m_sticky;
  logic [CNT_W-1:0]       m_excCount;
  logic                   m_dropped;
  logic                   m_clearSticky;
  modport master (
    output m_inValid, m_dataIn, m_statusIn, m_outReady, m_clearSticky,
    input  m_inReady, m_outValid, m_dataOut, m_statusOut, m_level, m_sticky, m_excCount, m_dropped
  );
  modport slave (
    input  m_inValid, m_dataIn, m_statusIn, m_outReady, m_clearSticky,
    output m_inReady, m_outValid, m_dataOut, m_statusOut, m_level, m_sticky, m_excCount, m_dropped
  );
endinterface

// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: FIFO of FPU results with valid/ready output, sticky exception flags and saturating exception count.
module fpu_result_buffer
  import FPU_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic m_clk,
  input logic m_reset,
  fpu_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [31:0]   data_q [DEPTH];
  g_eStatus      stat_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    sticky_q, sticky_d;
  logic [CNT_W-1:0] exc_q, exc_d;
  logic          drop_q, drop_d;
  logic          full, empty, push, pop, flag;
  assign full  = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign push  = bus.m_inValid && !full;
  assign pop   = !empty && bus.m_outReady;
  assign flag  = push && bus.m_statusIn != EXACT;
  always_comb begin
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    sticky_d = (bus.m_clearSticky ? 3'b000 : sticky_q)
             | ({3{push}} & {bus.m_statusIn == INEXACT, bus.m_statusIn == UNDERFLOW, bus.m_statusIn == OVERFLOW});
    exc_d    = bus.m_clearSticky ? CNT_W'(flag) : (flag && exc_q != '1) ? exc_q + 1'b1 : exc_q;
    drop_d   = (bus.m_clearSticky ? 1'b0 : drop_q) | (bus.m_inValid && full);
  end
  always_ff @(posedge m_clk) begin
    if (m_reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      level_q  <= '0;
      sticky_q <= '0;
      exc_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      level_q  <= level_d;
      sticky_q <= sticky_d;
      exc_q    <= exc_d;
      drop_q   <= drop_d;
    end
  end
  // Storage needs no reset: outputs are forced to 0/EXACT whenever the FIFO is empty.
  always_ff @(posedge m_clk) begin
    if (push) begin
      data_q[wr_q] <= bus.m_dataIn;
      stat_q[wr_q] <= bus.m_statusIn;
    end
  end
  assign bus.m_inReady     = !full;
  assign bus.m_outValid    = !empty;
  assign bus.m_dataOut     = empty ? 32'h0 : data_q[rd_q];
  assign bus.m_statusOut   = empty ? EXACT : stat_q[rd_q];
  assign bus.m_level       = level_q;
  assign bus.m_sticky      = sticky_q;
  assign bus.m_excCount    = exc_q;
  assign bus.m_dropped     = drop_q;
endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb_fpu_result_buffer: directed scoreboard bench for fpu_result_buffer (CNT_W=8 main instance, CNT_W=2 saturation instance).
module tb_fpu_result_buffer;
  import FPU_types::*;
  localparam int DEPTH = 4;
  typedef struct packed {logic [31:0] d; g_eStatus s;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ent_t sb[$];
  int lvl = 0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  fpu_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(8)) a ();
  fpu_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(2)) b ();
  fpu_result_buffer #(.DEPTH(DEPTH), .CNT_W(8)) dut (.m_clk(clk), .m_reset(rst), .bus(a.slave));
  fpu_result_buffer #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (.m_clk(clk), .m_reset(rst), .bus(b.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit psh, pp;
    ent_t e;
    @(negedge clk);
    psh = a.m_inValid && lvl != DEPTH && !rst;
    pp  = a.m_outReady && lvl != 0 && !rst;
    if (pp) begin
      e = sb.pop_front();
      chk("head_data", a.m_dataOut, e.d);
      chk("head_status", a.m_statusOut, e.s);
    end
    if (psh) sb.push_back({a.m_dataIn, a.m_statusIn});
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      lvl = 0;
    end else lvl = lvl + int'(psh) - int'(pp);
    chk("level", a.m_level, lvl);
    chk("out_valid", a.m_outValid, lvl != 0);
    chk("in_ready", a.m_inReady, lvl != DEPTH);
    if (lvl == 0) chk("empty_data", a.m_dataOut, 0);
  endtask
  task automatic push(input logic [31:0] d, input g_eStatus s);
    a.m_inValid  = 1'b1;
    a.m_dataIn   = d;
    a.m_statusIn = s;
    tick();
    a.m_inValid  = 1'b0;
  endtask
  task automatic chk_reset();
    chk("rst_data", a.m_dataOut, 0);
    chk("rst_status", a.m_statusOut, EXACT);
    chk("rst_sticky", a.m_sticky, 0);
    chk("rst_exc", a.m_excCount, 0);
    chk("rst_dropped", a.m_dropped, 0);
    chk("rst_exc_b", b.m_excCount, 0);
  endtask
  initial begin
    a.m_inValid = 1'b0; a.m_dataIn = '0; a.m_statusIn = EXACT; a.m_outReady = 1'b0; a.m_clearSticky = 1'b0;
    b.m_inValid = 1'b0; b.m_dataIn = '0; b.m_statusIn = EXACT; b.m_outReady = 1'b0; b.m_clearSticky = 1'b0;
    tick();
    rst = 1'b0;
    chk_reset();
    // T1: single push, visible the cycle after the edge
    push(32'h4000_0000, EXACT);
    chk("t1_data", a.m_dataOut, 32'h4000_0000);
    chk("t1_sticky", a.m_sticky, 3'b000);
    chk("t1_exc", a.m_excCount, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // T2: fill with outReady low
    push(32'h4008_0000, EXACT);
    push(32'h0000_0000, EXACT);
    push(32'h7FF0_0000, OVERFLOW);
    push(32'h40A0_01FF, INEXACT);
    chk("t2_sticky", a.m_sticky, 3'b101);
    chk("t2_exc", a.m_excCount, 2);
    tick();
    chk("t2_hold_data", a.m_dataOut, 32'h4008_0000);
    chk("t2_hold_status", a.m_statusOut, EXACT);
    // T3: push while full is dropped, even with a simultaneous pop
    push(32'h3FF0_0000, INEXACT);
    chk("t3_dropped", a.m_dropped, 1);
    chk("t3_exc", a.m_excCount, 2);
    a.m_outReady = 1'b1;
    push(32'h3FF0_0000, INEXACT);
    chk("t3_sticky", a.m_sticky, 3'b101);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_drained", sb.size(), 0);
    // T4: steady push+pop at level 2 across pointer wrap
    a.m_outReady = 1'b0;
    push(32'h1000_0000, EXACT);
    push(32'h1000_0001, EXACT);
    a.m_outReady = 1'b1;
    for (int i = 2; i < 12; i++) push(32'h1000_0000 + 32'(i), EXACT);
    tick();
    tick();
    // T5: clear with a flagged push in the same cycle
    a.m_clearSticky = 1'b1;
    push(32'h0000_0000, UNDERFLOW);
    a.m_clearSticky = 1'b0;
    chk("t5_sticky", a.m_sticky, 3'b010);
    chk("t5_exc", a.m_excCount, 1);
    chk("t5_dropped", a.m_dropped, 0);
    tick();
    // T6: mid-operation reset
    a.m_outReady = 1'b0;
    a.m_clearSticky = 1'b1;
    push(32'h40A0_01FF, INEXACT);
    a.m_clearSticky = 1'b0;
    push(32'h4010_0000, EXACT);
    push(32'h4020_0000, EXACT);
    chk("t6_sticky", a.m_sticky, 3'b100);
    chk("t6_exc", a.m_excCount, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset();
    // CNT_W=2 instance: count saturates at 3
    b.m_outReady = 1'b1;
    b.m_inValid  = 1'b1;
    b.m_statusIn = INEXACT;
    for (int i = 0; i < 5; i++) begin
      b.m_dataIn = 32'h3F00_0000 + 32'(i);
      tick();
      chk("b_exc", b.m_excCount, (i + 1 > 3) ? 3 : i + 1);
    end
    b.m_inValid = 1'b0;
    chk("b_sticky", b.m_sticky, 3'b100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
